// File: rtl/decoder_reg_pkg.sv
// decoder_reg_pkg: shared constants and FSM encoding for decoder_reg and the encoder loopback bench
package decoder_reg_pkg;
    localparam int IN_W_DEF = 3;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;
endpackage

// File: rtl/onehot_dec.sv
// onehot_dec: combinational binary-to-one-hot decoder
// ports: code_i (binary code in), onehot_o (1 << code_i)
module onehot_dec #(
    parameter  int IN_W  = 3,
    localparam int OUT_W = 2**IN_W
) (
    input  logic [IN_W-1:0]  code_i,
    output logic [OUT_W-1:0] onehot_o
);
    assign onehot_o = OUT_W'(1) << code_i;
endmodule

// File: rtl/decoder_reg.sv
// decoder_reg: registered 3-to-8 one-hot decoder with valid/ready handshakes and a code sweep sequencer
// ports: clk/rst (async active-high); in_valid/in_code/in_ready (code source side);
//        out_valid/out_onehot/out_ready (one-hot consumer side); sweep_start/sweep_busy/sweep_done (sequencer)
module decoder_reg
    import decoder_reg_pkg::*;
#(
    parameter  int IN_W  = IN_W_DEF,
    localparam int OUT_W = 2**IN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_code,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_onehot,
    input  logic             out_ready,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done
);
    state_e           state_q, state_d;
    logic [IN_W:0]    cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_onehot_q, out_onehot_d;
    logic             sweep_done_q, sweep_done_d;
    logic             free, sweep_load, load;
    logic [IN_W-1:0]  code;
    logic [OUT_W-1:0] dec;
    // entry can take a new word when empty or being drained this cycle
    assign free       = !out_valid_q || out_ready;
    assign in_ready   = (state_q == ST_IDLE) && !sweep_start && free;
    assign sweep_load = (state_q == ST_SWEEP) && free;
    assign load       = (in_valid && in_ready) || sweep_load;
    assign code       = sweep_load ? cnt_q[IN_W-1:0] : in_code;
    onehot_dec #(.IN_W(IN_W)) u_dec (
        .code_i   (code),
        .onehot_o (dec)
    );
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sweep_done_d = 1'b0;
        out_valid_d  = load || (out_valid_q && !out_ready);
        out_onehot_d = load ? dec : out_onehot_q;
        case (state_q)
            ST_IDLE: begin
                if (sweep_start) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (free) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == (IN_W+1)'(OUT_W-1)) ? ST_DRAIN : ST_SWEEP;
                end
            end
            ST_DRAIN: begin
                // only the last sweep word can be in the entry here
                if (out_valid_q && out_ready) begin
                    state_d      = ST_IDLE;
                    sweep_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_onehot_q <= '0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_onehot_q <= out_onehot_d;
            sweep_done_q <= sweep_done_d;
        end
    end
    assign out_valid  = out_valid_q;
    assign out_onehot = out_onehot_q;
    assign sweep_busy = (state_q != ST_IDLE);
    assign sweep_done = sweep_done_q;
endmodule

// File: tb/tb_decoder_reg.sv
// tb_decoder_reg: directed and random checks of decoder_reg against a queue-based transaction model
module tb_decoder_reg;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [2:0] in_code;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_onehot;
    logic       out_ready;
    logic       sweep_start;
    logic       sweep_busy;
    logic       sweep_done;

    int total = 0;
    int bad   = 0;
    int xfers = 0;

    int m_q[$];
    bit m_busy;
    bit m_done;
    int sw_next;

    decoder_reg dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_code     (in_code),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_onehot  (out_onehot),
        .out_ready   (out_ready),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int encode(input logic [7:0] w);
        int e = -1;
        for (int i = 0; i < 8; i++) if (w[i]) e = i;
        return e;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_busy  = 1'b0;
        m_done  = 1'b0;
        sw_next = 0;
    endtask

    // one clock cycle: drive, check against the model, clock, advance the model
    task automatic step(input bit iv, input logic [2:0] ic, input bit orr, input bit ss);
        bit free, er, popped;
        in_valid = iv; in_code = ic; out_ready = orr; sweep_start = ss;
        #1;
        free = (m_q.size() == 0) || orr;
        er   = !m_busy && !ss && free;
        chk("in_ready", in_ready, er);
        chk("out_valid", out_valid, m_q.size() != 0);
        chk("sweep_busy", sweep_busy, m_busy);
        chk("sweep_done", sweep_done, m_done);
        if (m_q.size() != 0) begin
            chk("out_onehot", out_onehot, 8'd1 << m_q[0]);
            if (orr) begin
                chk("loopback", encode(out_onehot), m_q[0]);
                xfers++;
            end
        end
        @(posedge clk);
        popped = (m_q.size() != 0) && orr;
        if (popped) void'(m_q.pop_front());
        m_done = 1'b0;
        if (!m_busy) begin
            if (ss) begin
                m_busy  = 1'b1;
                sw_next = 0;
            end else if (iv && er) m_q.push_back(int'(ic));
        end else if (sw_next == 8) begin
            if (popped) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else if (free) begin
            m_q.push_back(sw_next);
            sw_next++;
        end
        #1;
    endtask

    initial begin
        int n0;
        rst = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b0; sweep_start = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_onehot", out_onehot, 8'h00);
        chk("rst_busy", sweep_busy, 1'b0);
        chk("rst_done", sweep_done, 1'b0);
        rst = 1'b0;

        // single decode
        step(1, 3'd7, 1, 0);
        chk("single_80", out_onehot, 8'h80);
        step(1, 3'd1, 1, 0);
        chk("single_02", out_onehot, 8'h02);
        step(0, 3'd0, 1, 0);

        // back-pressure
        step(1, 3'd5, 0, 0);
        repeat (3) step(1, 3'd2, 0, 0);
        chk("bp_hold", out_onehot, 8'h20);
        step(1, 3'd2, 1, 0);
        chk("bp_next", out_onehot, 8'h04);
        step(0, 3'd0, 1, 0);

        // full sweep
        n0 = xfers;
        step(0, 3'd0, 1, 1);
        repeat (11) step(0, 3'd0, 1, 0);
        chk("sweep_words", xfers - n0, 8);

        // collision and ignored restart
        n0 = xfers;
        step(1, 3'd4, 1, 1);
        step(0, 3'd0, 1, 0);
        step(0, 3'd0, 1, 0);
        step(1, 3'd3, 1, 1);
        repeat (10) step(0, 3'd0, 1, 0);
        chk("collide_words", xfers - n0, 8);

        // reset mid-sweep
        step(0, 3'd0, 1, 1);
        repeat (3) step(0, 3'd0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_valid", out_valid, 1'b0);
        chk("mid_onehot", out_onehot, 8'h00);
        chk("mid_busy", sweep_busy, 1'b0);
        @(posedge clk);
        #1;
        chk("hold_busy", sweep_busy, 1'b0);
        rst = 1'b0;
        model_reset();
        repeat (12) step(0, 3'd0, 1, 0);

        // random traffic with occasional sweeps
        repeat (400) step(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
        // random loopback without sweeps, then drain
        repeat (300) step(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          bit'($urandom_range(0, 1)), 0);
        repeat (12) step(0, 3'd0, 1, 0);
        chk("drained", m_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decoder_reg.md
Name: decoder_reg

Overview:
- Registered 3-to-8 one-hot decoder with valid/ready handshakes on both sides; the inverse of the team's 8-to-3 encoder.
- Drives one-hot select lines from a binary code.
- Includes a built-in sweep sequencer that walks every code in order, for bring-up and encoder/decoder loopback checks.
- Sits between a code source (controller or encoder output) and one-hot select consumers.

Parameters:
- IN_W, 3, width of the binary input code.
- OUT_W, 2**IN_W (localparam, not overridable), width of the one-hot output.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  in_code is valid this cycle.
- in_code  input  IN_W  binary code to decode.
- in_ready  output  1  block accepts in_code this cycle.
- out_valid  output  1  out_onehot holds a valid word.
- out_onehot  output  OUT_W  decoded one-hot word; bit[in_code] = 1.
- out_ready  input  1  consumer accepts out_onehot this cycle.
- sweep_start  input  1  single-cycle request to run a sweep.
- sweep_busy  output  1  sweep in progress.
- sweep_done  output  1  one-cycle pulse after the last sweep word is accepted.

Behaviour:
- Interface decision: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: out_valid=0, out_onehot=0, sweep_busy=0, sweep_done=0, FSM=IDLE, sweep counter=0.
- Output stage is a single register entry.
  - Transfer out occurs when out_valid && out_ready.
  - Transfer in occurs when in_valid && in_ready.
- in_ready = (state==IDLE) && !sweep_start && (!out_valid || out_ready). This is combinational, so full throughput is sustained under back-pressure release.
- Latency: code accepted at edge N appears on out_onehot with out_valid=1 after edge N, i.e. 1 cycle.
- out_onehot is exactly one-hot whenever out_valid=1. While out_valid=1 && !out_ready, out_onehot and out_valid hold stable.
- Load rule: on any load, out_onehot = 1 << code, out_valid = 1.
  - If the entry drains with no new load, out_valid -> 0. out_onehot keeps its last value; consumers ignore it.
- FSM states:
  - IDLE: normal decode. sweep_start=1 -> SWEEP, counter=0. sweep_start has priority over a simultaneous in_valid; that code is not accepted (in_ready=0).
  - SWEEP: sweep_busy=1 and in_ready=0.
    - Whenever the output entry is free or draining, load 1 << counter and increment counter. A pending normal word already in the output register drains first, unaltered.
    - After loading code OUT_W-1, go to DRAIN.
  - DRAIN: sweep_busy=1. When the last sweep word is accepted, go to IDLE and pulse sweep_done=1 for one cycle.
- sweep_start while sweep_busy=1 is ignored.
- Counter is IN_W+1 bits wide so the end condition does not wrap; only the low IN_W bits are used as the code.
- Reset mid-operation: all state is cleared immediately and asynchronously. The in-flight word is dropped and no sweep_done is produced.
- No X on any output after reset; in_code is sampled only when in_valid && in_ready.

Decomposition:
- Shared package/header: IN_W default and the FSM state encoding (ST_IDLE=2'd0, ST_SWEEP=2'd1, ST_DRAIN=2'd2).
- These constants are reused by the encoder loopback bench.
- Natural sub-module: onehot_dec, purely combinational (code -> 1<<code), instantiated once and shared by the normal and sweep paths through a code mux.
- The FSM and output register stay in decoder_reg.

Test Plan:
- Reset mid-sweep:
  - Stimulus: rst pulse, then hold rst=1 with sweep running.
  - Response: out_valid=0, out_onehot=8'h00, sweep_busy=0 immediately; no sweep_done afterward.
- Single decode:
  - Stimulus: out_ready=1; in_code=3'b111 with in_valid, then 3'b001.
  - Response: out_onehot=8'b10000000 one cycle later, then 8'b00000010, each with out_valid=1.
- Back-pressure:
  - Stimulus: out_ready=0; send code 3'd5; hold in_valid with code 3'd2.
  - Response: 8'b00100000 held stable, in_ready=0. After out_ready=1, 8'b00000100 follows on the next cycle.
- Full sweep:
  - Stimulus: sweep_start pulse with out_ready=1.
  - Response: eight consecutive words 8'h01, 8'h02 … 8'h80; sweep_busy high throughout; sweep_done one cycle after 8'h80 is accepted.
- Collision:
  - Stimulus: sweep_start and in_valid (code 3'd4) in the same cycle; sweep_start again mid-sweep.
  - Response: code 4 not accepted (in_ready=0); exactly one sweep of 8 words.
- Loopback:
  - Stimulus: chain decoder_reg into the 8-to-3 encoder and drive random codes 0..7 with random out_ready.
  - Response: encoder output equals each input code, in order, with no drops or duplicates.
